// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code input path.
// Holds the conditioner state enum, default width and Hamming helper.
package gray_pkg;

    localparam int GRAY_W   = 4;
    localparam int HAMM_MAX = 32;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        IDLE   = 2'd1,
        SETTLE = 2'd2
    } gray_cond_state_t;

    // Popcount of a ^ b; callers zero-extend words up to HAMM_MAX bits.
    function automatic int unsigned hamming(
        input logic [HAMM_MAX-1:0] a,
        input logic [HAMM_MAX-1:0] b
    );
        logic [HAMM_MAX-1:0] x;
        int unsigned         n;
        x = a ^ b;
        n = 0;
        for (int i = 0; i < HAMM_MAX; i++) begin
            n += {31'd0, x[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/gray_input_conditioner_sync.sv
// Two-flop per-bit synchronizer, async active-low reset to 0.
// Ports: clk, rst_n, d_i (async word), q_o (clk-domain word).
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/gray_input_conditioner.sv
// Synchronizes and debounces a raw Gray word, strobes accepted words.
// Ports: clk, rst_n, gray_raw in; gray_out, gray_valid, step_err, busy out.
module gray_input_conditioner
    import gray_pkg::*;
#(
    parameter int WIDTH         = GRAY_W,
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray_raw,
    output logic [WIDTH-1:0] gray_out,
    output logic             gray_valid,
    output logic             step_err,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] s;

    gray_cond_state_t state_q, state_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    sync_2ff #(
        .WIDTH (WIDTH)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (gray_raw),
        .q_o   (s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            cand_q  <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            INIT, SETTLE: begin
                // A mismatch always restarts, even on the would-be commit edge.
                if (s != cand_q) begin
                    cand_d = s;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    // First commit after reset always strobes; later ones
                    // only when the word actually moved away from gray_out.
                    if (state_q == INIT || cand_q != out_q) begin
                        out_d   = cand_q;
                        valid_d = 1'b1;
                        err_d   = (state_q == SETTLE) &&
                                  (hamming(HAMM_MAX'(cand_q),
                                           HAMM_MAX'(out_q)) > 1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            IDLE: begin
                if (s != out_q) begin
                    cand_d  = s;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    assign gray_out   = out_q;
    assign gray_valid = valid_q;
    assign step_err   = err_q;
    assign busy       = (state_q != IDLE);

endmodule
